// File: rtl/jpeg_byte_packer.sv
// jpeg_byte_packer
// Packs MSB-aligned variable-length Huffman code words into a JPEG byte
// stream: 0xFF bytes are followed by a stuffed 0x00, the final partial byte
// is padded with 1s, and the EOI marker (FF D9) is optionally appended.
//
// Handshake semantics (both ports): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer never retracts valid
// or changes its payload while valid & !ready; ready may change freely.
// out_valid/out_data/out_last are registered; in_ready is a combinational
// function of registered state only (never of in_valid).

module jpeg_byte_packer #(
   parameter int ACC_W      = 128,
   parameter bit APPEND_EOI = 1'b1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_code,
   input  logic [6:0]       in_size,
   input  logic             in_eop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             frame_done,
   output logic [CNT_W-1:0] byte_count
);

   // bit_cnt_q must hold values 0..ACC_W inclusive
   localparam int CW = $clog2(ACC_W + 1);
   localparam logic [CW-1:0] IN_LIM    = CW'(ACC_W - 64);
   localparam logic [CW-1:0] BYTE_BITS = CW'(8);
   localparam logic [CW-1:0] CNT_ZERO  = '0;

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_STUFF = 3'd1,
      S_PAD   = 3'd2,
      S_EOI1  = 3'd3,
      S_EOI2  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Observable FSM state; checkers bind to state_q and bit_cnt_q directly
   state_t            state_q;
   // Pending bits, MSB-aligned: valid bits live in acc_q[ACC_W-1 -: bit_cnt_q],
   // everything below them is kept at zero so padding can simply OR in 1s.
   logic [ACC_W-1:0]  acc_q;
   logic [CW-1:0]     bit_cnt_q;
   // The eop word of the current frame has been accepted
   logic              eop_seen_q;
   // Low through reset and the first clock after it, so in_ready is 0 in reset
   logic              armed_q;
   // byte_count restarts at the next accepted word
   logic              cnt_clr_q;

   logic              out_free;
   logic              accept;
   logic              out_hs;
   logic [7:0]        top_byte;
   logic              has_byte;
   logic              run_pop;
   logic [6:0]        size_eff;
   logic [63:0]       code_bits;
   logic [ACC_W-1:0]  acc_popped;
   logic [CW-1:0]     cnt_popped;
   logic [ACC_W-1:0]  acc_next;
   logic [CW-1:0]     cnt_next;
   logic              last_data;
   logic [7:0]        pad_byte;

   // Handshake qualifiers and the next accumulator value for RUN
   always_comb begin
      out_free  = !out_valid || out_ready;
      out_hs    = out_valid && out_ready;
      in_ready  = armed_q && (state_q == S_RUN) && !eop_seen_q &&
                  (bit_cnt_q <= IN_LIM);
      accept    = in_valid && in_ready;
      top_byte  = acc_q[ACC_W-1 -: 8];
      has_byte  = (bit_cnt_q >= BYTE_BITS);
      run_pop   = (state_q == S_RUN) && has_byte && out_free;

      // Oversized words are clamped; bits below the used field are dropped
      size_eff  = (in_size > 7'd64) ? 7'd64 : in_size;
      code_bits = in_code & ~({64{1'b1}} >> size_eff);

      // The pop happens first, then the new word lands directly below the
      // remaining bits. Accept needs bit_cnt <= ACC_W-64, so nothing falls
      // off the bottom of the accumulator.
      acc_popped = run_pop ? (acc_q << 8) : acc_q;
      cnt_popped = run_pop ? (bit_cnt_q - BYTE_BITS) : bit_cnt_q;
      acc_next   = acc_popped;
      cnt_next   = cnt_popped;
      if (accept) begin
         acc_next = acc_popped | ({code_bits, {(ACC_W-64){1'b0}}} >> cnt_popped);
         cnt_next = cnt_popped + CW'(size_eff);
      end

      // Without EOI, a data byte is final only if the frame is known to be
      // complete, nothing is left over and no stuff byte has to follow it.
      last_data = !APPEND_EOI && (eop_seen_q || (accept && in_eop)) &&
                  (cnt_next == CNT_ZERO) && (top_byte != 8'hFF);

      // Remaining bits left-justified, low bits filled with 1s
      pad_byte  = top_byte | (8'hFF >> bit_cnt_q);
   end

   // Framing FSM with the bit accumulator and the registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_RUN;
         acc_q      <= '0;
         bit_cnt_q  <= '0;
         eop_seen_q <= 1'b0;
         armed_q    <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= 8'h00;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         armed_q    <= 1'b1;
         frame_done <= 1'b0;
         // A drained output register empties unless a new byte is loaded below
         if (out_free) begin
            out_valid <= 1'b0;
         end
         if (accept && in_eop) begin
            eop_seen_q <= 1'b1;
         end

         case (state_q)
            S_RUN: begin
               acc_q     <= acc_next;
               bit_cnt_q <= cnt_next;
               if (run_pop) begin
                  out_valid <= 1'b1;
                  out_data  <= top_byte;
                  out_last  <= last_data;
                  if (top_byte == 8'hFF) begin
                     state_q <= S_STUFF;
                  end
               end else if (eop_seen_q && !has_byte) begin
                  state_q <= S_PAD;
               end
            end

            S_STUFF: begin
               if (out_free) begin
                  out_valid <= 1'b1;
                  out_data  <= 8'h00;
                  out_last  <= !APPEND_EOI && eop_seen_q && (bit_cnt_q == CNT_ZERO);
                  state_q   <= (eop_seen_q && !has_byte) ? S_PAD : S_RUN;
               end
            end

            S_PAD: begin
               if (bit_cnt_q != CNT_ZERO) begin
                  if (out_free) begin
                     out_valid <= 1'b1;
                     out_data  <= pad_byte;
                     out_last  <= !APPEND_EOI && (pad_byte != 8'hFF);
                     acc_q     <= '0;
                     bit_cnt_q <= '0;
                     if (pad_byte == 8'hFF) begin
                        // STUFF comes back here with zero bits left
                        state_q <= S_STUFF;
                     end else begin
                        state_q <= APPEND_EOI ? S_EOI1 : S_DONE;
                     end
                  end
               end else begin
                  state_q <= APPEND_EOI ? S_EOI1 : S_DONE;
               end
            end

            S_EOI1: begin
               // Marker bytes bypass stuffing
               if (out_free) begin
                  out_valid <= 1'b1;
                  out_data  <= 8'hFF;
                  out_last  <= 1'b0;
                  state_q   <= S_EOI2;
               end
            end

            S_EOI2: begin
               if (out_free) begin
                  out_valid <= 1'b1;
                  out_data  <= 8'hD9;
                  out_last  <= 1'b1;
                  state_q   <= S_DONE;
               end
            end

            S_DONE: begin
               // Pulse only once the final byte has left the output register
               if (out_free) begin
                  frame_done <= 1'b1;
                  eop_seen_q <= 1'b0;
                  state_q    <= S_RUN;
               end
            end

            default: begin
               state_q <= S_RUN;
            end
         endcase
      end
   end

   // Byte counter: counts output handshakes, restarts on the first accept
   // of a new frame (the frame_done cycle itself may already accept)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_count <= '0;
         cnt_clr_q  <= 1'b1;
      end else begin
         if (accept && (cnt_clr_q || frame_done)) begin
            byte_count <= CNT_W'(out_hs);
            cnt_clr_q  <= 1'b0;
         end else begin
            byte_count <= byte_count + CNT_W'(out_hs);
            if (frame_done) begin
               cnt_clr_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Testbench for jpeg_byte_packer: one instance with EOI appended, one without.
// Expected bytes are queued when stimulus is issued; monitors compare every
// output handshake and every frame_done against the queues.

module tb_jpeg_byte_packer;

   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic rst_n;

   // instance 0: APPEND_EOI = 1
   logic             in_valid0, in_ready0, in_eop0;
   logic [63:0]      in_code0;
   logic [6:0]       in_size0;
   logic             out_valid0, out_ready0, out_last0, frame_done0;
   logic [7:0]       out_data0;
   logic [CNT_W-1:0] byte_count0;

   // instance 1: APPEND_EOI = 0
   logic             in_valid1, in_ready1, in_eop1;
   logic [63:0]      in_code1;
   logic [6:0]       in_size1;
   logic             out_valid1, out_ready1, out_last1, frame_done1;
   logic [7:0]       out_data1;
   logic [CNT_W-1:0] byte_count1;

   // scoreboard state: {last, data} per byte, byte_count per frame
   logic [8:0]       exp_q0[$];
   logic [8:0]       exp_q1[$];
   logic [CNT_W-1:0] bc_q0[$];
   logic [CNT_W-1:0] bc_q1[$];

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt0 = 0;
   int done_cnt1 = 0;
   int acc_cnt0  = 0;
   logic drv_done0;

   jpeg_byte_packer #(.ACC_W(128), .APPEND_EOI(1'b1), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_code(in_code0),
      .in_size(in_size0), .in_eop(in_eop0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .out_last(out_last0), .frame_done(frame_done0), .byte_count(byte_count0)
   );

   jpeg_byte_packer #(.ACC_W(128), .APPEND_EOI(1'b0), .CNT_W(CNT_W)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_code(in_code1),
      .in_size(in_size1), .in_eop(in_eop1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_last(out_last1), .frame_done(frame_done1), .byte_count(byte_count1)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- monitor, instance 0 ----------------
   logic       stall0, expect_done0, prev_done0;
   logic [8:0] prev0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall0       = 1'b0;
         expect_done0 = 1'b0;
         prev_done0   = 1'b0;
      end else begin
         if (expect_done0) begin
            check("done_after_d9", frame_done0, 1'b1);
            expect_done0 = 1'b0;
         end
         if (stall0) begin
            check("stall_valid0", out_valid0, 1'b1);
            check("stall_stable0", {out_last0, out_data0}, prev0);
         end
         if (in_valid0 && in_ready0) acc_cnt0++;
         if (out_valid0 && out_ready0) begin
            if (exp_q0.size() == 0) begin
               check("unexpected_byte0", {out_last0, out_data0}, 9'h1FF ^ {out_last0, out_data0});
            end else begin
               check("byte0", {out_last0, out_data0}, exp_q0.pop_front());
            end
            if (out_last0 && out_data0 == 8'hD9) expect_done0 = 1'b1;
         end
         if (frame_done0) begin
            done_cnt0++;
            check("done_width0", prev_done0, 1'b0);
            check("done_drained0", exp_q0.size(), 0);
            if (bc_q0.size() != 0) check("byte_count0", byte_count0, bc_q0.pop_front());
         end
         prev_done0 = frame_done0;
         stall0     = out_valid0 && !out_ready0;
         prev0      = {out_last0, out_data0};
      end
   end

   // ---------------- monitor, instance 1 ----------------
   logic prev_done1;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_done1 = 1'b0;
      end else begin
         if (out_valid1 && out_ready1) begin
            if (exp_q1.size() == 0) begin
               check("unexpected_byte1", {out_last1, out_data1}, 9'h1FF ^ {out_last1, out_data1});
            end else begin
               check("byte1", {out_last1, out_data1}, exp_q1.pop_front());
            end
         end
         if (frame_done1) begin
            done_cnt1++;
            check("done_width1", prev_done1, 1'b0);
            check("done_drained1", exp_q1.size(), 0);
            if (bc_q1.size() != 0) check("byte_count1", byte_count1, bc_q1.pop_front());
         end
         prev_done1 = frame_done1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int sel, input logic [63:0] code, input logic [6:0] size,
                       input logic eop);
      int  n  = 0;
      bit  ok = 0;
      if (sel == 0) begin
         in_valid0 = 1'b1; in_code0 = code; in_size0 = size; in_eop0 = eop;
      end else begin
         in_valid1 = 1'b1; in_code1 = code; in_size1 = size; in_eop1 = eop;
      end
      while (!ok && n < 300) begin
         @(negedge clk);
         if ((sel == 0) ? in_ready0 : in_ready1) begin
            @(posedge clk);
            #1;
            ok = 1;
         end else begin
            n++;
         end
      end
      if (!ok) check("accept_timeout", 1'b1, 1'b0);
      if (sel == 0) in_valid0 = 1'b0;
      else          in_valid1 = 1'b0;
   endtask

   task automatic wait_done(input int sel);
      int start = (sel == 0) ? done_cnt0 : done_cnt1;
      int n = 0;
      while (((sel == 0) ? done_cnt0 : done_cnt1) == start && n < 400) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("frame_done_timeout", (((sel == 0) ? done_cnt0 : done_cnt1) == start), 1'b0);
   endtask

   task automatic push0(input logic [7:0] d, input logic last);
      exp_q0.push_back({last, d});
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      in_valid0 = 0; in_code0 = '0; in_size0 = '0; in_eop0 = 0; out_ready0 = 1'b1;
      in_valid1 = 0; in_code1 = '0; in_size1 = '0; in_eop1 = 0; out_ready1 = 1'b1;
      drv_done0 = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid0, 1'b0);
      check("rst_out_last", out_last0, 1'b0);
      check("rst_out_data", out_data0, 8'h00);
      check("rst_frame_done", frame_done0, 1'b0);
      check("rst_byte_count", byte_count0, 0);
      check("rst_in_ready", in_ready0, 1'b0);
      check("rst_out_valid1", out_valid1, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", in_ready0, 1'b1);

      // basic packing: ABC (12 bits) -> AB CF FF D9
      push0(8'hAB, 0); push0(8'hCF, 0); push0(8'hFF, 0); push0(8'hD9, 1);
      bc_q0.push_back(4);
      send(0, 64'hABC0_0000_0000_0000, 7'd12, 1'b1);
      wait_done(0);

      // stuffing: FF, then empty eop word -> FF 00 FF D9
      push0(8'hFF, 0); push0(8'h00, 0); push0(8'hFF, 0); push0(8'hD9, 1);
      bc_q0.push_back(4);
      send(0, 64'hFF00_0000_0000_0000, 7'd8, 1'b0);
      send(0, 64'h0, 7'd0, 1'b1);
      wait_done(0);

      // padding that produces FF must be stuffed
      push0(8'hFF, 0); push0(8'h00, 0); push0(8'hFF, 0); push0(8'hD9, 1);
      bc_q0.push_back(4);
      send(0, 64'hFE00_0000_0000_0000, 7'd7, 1'b1);
      wait_done(0);

      // oversized in_size is clamped to 64
      push0(8'h11, 0); push0(8'h22, 0); push0(8'h33, 0); push0(8'h44, 0);
      push0(8'h55, 0); push0(8'h66, 0); push0(8'h77, 0); push0(8'h88, 0);
      push0(8'hFF, 0); push0(8'hD9, 1);
      bc_q0.push_back(10);
      send(0, 64'h1122_3344_5566_7788, 7'd100, 1'b1);
      wait_done(0);

      // backpressure: 9 full words, out_ready low for 5 cycles then random
      for (int w = 0; w < 9; w++) begin
         for (int b = 0; b < 8; b++) begin
            logic [63:0] pat;
            pat = 64'h0123_4567_89AB_CDEF;
            push0(pat[63 - 8*b -: 8], 0);
         end
      end
      push0(8'hFF, 0); push0(8'hD9, 1);
      bc_q0.push_back(74);
      acc_cnt0  = 0;
      drv_done0 = 1'b0;
      out_ready0 = 1'b0;
      fork
         begin
            for (int w = 0; w < 9; w++) send(0, 64'h0123_4567_89AB_CDEF, 7'd64, (w == 8));
            drv_done0 = 1'b1;
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            // two full words fill the accumulator past ACC_W-64 with the sink stalled
            check("bp_words_accepted", acc_cnt0, 2);
            check("bp_in_ready_low", in_ready0, 1'b0);
            while (!drv_done0) begin
               @(posedge clk);
               #1;
               out_ready0 = 1'($urandom_range(0, 1));
            end
            out_ready0 = 1'b1;
         end
      join
      wait_done(0);

      // reset mid-frame discards buffered bits
      out_ready0 = 1'b0;
      send(0, 64'hABCD_E000_0000_0000, 7'd20, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_valid", out_valid0, 1'b1);
      check("pre_reset_data", out_data0, 8'hAB);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", out_valid0, 1'b0);
      check("async_reset_count", byte_count0, 0);
      check("async_reset_ready", in_ready0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready0 = 1'b1;
      push0(8'h12, 0); push0(8'hFF, 0); push0(8'hD9, 1);
      bc_q0.push_back(3);
      send(0, 64'h1200_0000_0000_0000, 7'd8, 1'b1);
      wait_done(0);

      // no EOI: single byte carries out_last
      exp_q1.push_back({1'b1, 8'h5A});
      bc_q1.push_back(1);
      send(1, 64'h5A00_0000_0000_0000, 7'd8, 1'b1);
      wait_done(1);

      // no EOI: FF data byte, last flag moves to the stuff byte
      exp_q1.push_back({1'b0, 8'hFF});
      exp_q1.push_back({1'b1, 8'h00});
      bc_q1.push_back(2);
      send(1, 64'hFF00_0000_0000_0000, 7'd8, 1'b1);
      wait_done(1);

      // no EOI: empty frame gives no bytes but still frame_done
      bc_q1.push_back(0);
      send(1, 64'h0, 7'd0, 1'b1);
      wait_done(1);

      repeat (5) @(posedge clk);
      #1;
      check("final_exp0_empty", exp_q0.size(), 0);
      check("final_exp1_empty", exp_q1.size(), 0);
      check("final_bc0_empty", bc_q0.size(), 0);
      check("final_bc1_empty", bc_q1.size(), 0);
      check("frames_done0", done_cnt0, 6);
      check("frames_done1", done_cnt1, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
